id_dispatch_queue: RTL and testbench

//  Parametrised decode->dispatch buffer: replaces the single-slot id/dispatch register with a

---
 rtl/id_dispatch_queue_pkg.sv | 29 ++
 rtl/id_dispatch_ring.sv | 33 +++
 rtl/id_dispatch_queue.sv | 113 +++++++++++
 tb/tb_id_dispatch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_dispatch_queue_pkg.sv
// Shared types for the decode->dispatch queue.
// ID_DISPATCH_QUEUE_PERF_EN adds the performance-counter struct.
package id_dispatch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [3:0]  fu_sel;
  } id_dispatch_t;

`ifdef ID_DISPATCH_QUEUE_PERF_EN
  typedef struct packed {
    logic [31:0] full_cyc;
    logic [31:0] flush_cnt;
  } dq_perf_t;
`endif

  // Lane masks are at most 4 wide; callers zero-extend narrower masks.
  function automatic logic [2:0] lane_popcount(input logic [3:0] mask);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/id_dispatch_ring.sv
// Ring storage for id_dispatch_queue: ISSUE_W write ports at wr_ptr+i and
// ISSUE_W combinational read ports at rd_ptr+i, indices wrapping mod DEPTH.
module id_dispatch_ring
  import id_dispatch_queue_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic [PTR_W-1:0]           wr_ptr,
  input  logic [ISSUE_W-1:0]         wr_en,
  input  id_dispatch_t [ISSUE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]           rd_ptr,
  output id_dispatch_t [ISSUE_W-1:0] rd_data
);

  id_dispatch_t mem [DEPTH];

  // Index expressions stay PTR_W wide so lanes straddling DEPTH-1 wrap to 0.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (wr_en[i]) mem[wr_ptr + PTR_W'(i)] <= wr_data[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      rd_data[i] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/id_dispatch_queue.sv
// In-order DEPTH-entry decode->dispatch queue, ISSUE_W lanes in and out.
// ID_DISPATCH_QUEUE_PERF_EN adds saturating full-cycle and flush counters.
module id_dispatch_queue
  import id_dispatch_queue_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         exception_flush,
  input  logic                         branch_flush,
  input  logic [ISSUE_W-1:0]           in_valid,
  input  id_dispatch_t [ISSUE_W-1:0]   in_data,
  output logic                         in_ready,
  output logic [ISSUE_W-1:0]           out_valid,
  output id_dispatch_t [ISSUE_W-1:0]   out_data,
  input  logic [$clog2(ISSUE_W+1)-1:0] out_pop_cnt
`ifdef ID_DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                  perf_full_cyc,
  output logic [31:0]                  perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned POP_W = $clog2(ISSUE_W + 1);

  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [POP_W-1:0]           push_n, pop_n;
  logic [ISSUE_W-1:0]         wr_en;
  logic                       flush;
  id_dispatch_t [ISSUE_W-1:0] rd_data;

  assign flush = exception_flush | branch_flush;
  assign pop_n = out_pop_cnt;

  // Registered count only: keeps out_pop_cnt off the in_ready path.
  assign in_ready = !rst && ((CNT_W'(DEPTH) - count) >= CNT_W'(ISSUE_W));

  always_comb begin
    push_n = '0;
    wr_en  = '0;
    if (in_ready) begin
      push_n = POP_W'(lane_popcount(4'(in_valid)));
    end
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      wr_en[i] = !flush && (POP_W'(i) < push_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  id_dispatch_ring #(
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_ring (
    .clk     (clk),
    .wr_ptr  (tail),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_ptr  (head),
    .rd_data (rd_data)
  );

  always_comb begin
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      out_valid[i] = count > CNT_W'(i);
      out_data[i]  = out_valid[i] ? rd_data[i] : '0;
    end
  end

`ifdef ID_DISPATCH_QUEUE_PERF_EN
  dq_perf_t perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf <= '0;
    end else begin
      if (!in_ready && perf.full_cyc != '1) perf.full_cyc <= perf.full_cyc + 32'd1;
      if (flush && perf.flush_cnt != '1)    perf.flush_cnt <= perf.flush_cnt + 32'd1;
    end
  end

  assign perf_full_cyc  = perf.full_cyc;
  assign perf_flush_cnt = perf.flush_cnt;
`endif

  a_pop_le_count: assert property (@(posedge clk) disable iff (rst)
    CNT_W'(pop_n) <= count);
  a_pop_le_lanes: assert property (@(posedge clk) disable iff (rst)
    pop_n <= POP_W'(ISSUE_W));
  a_in_valid_contig: assert property (@(posedge clk) disable iff (rst)
    (in_valid & (in_valid + ISSUE_W'(1))) == '0);

endmodule

// File: tb/tb_id_dispatch_queue.sv
// Directed self-checking bench for id_dispatch_queue (ISSUE_W=2, DEPTH=8).
// Perf counter checks run when ID_DISPATCH_QUEUE_PERF_EN is defined.
module tb_id_dispatch_queue;
  import id_dispatch_queue_pkg::*;

  logic               clk;
  logic               rst;
  logic               exception_flush;
  logic               branch_flush;
  logic [1:0]         in_valid;
  id_dispatch_t [1:0] in_data;
  logic               in_ready;
  logic [1:0]         out_valid;
  id_dispatch_t [1:0] out_data;
  logic [1:0]         out_pop_cnt;
`ifdef ID_DISPATCH_QUEUE_PERF_EN
  logic [31:0]        perf_full_cyc;
  logic [31:0]        perf_flush_cnt;
`endif

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  id_dispatch_t zero_d = '0;

  id_dispatch_queue #(
    .ISSUE_W (2),
    .DEPTH   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .exception_flush (exception_flush),
    .branch_flush    (branch_flush),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_pop_cnt     (out_pop_cnt)
`ifdef ID_DISPATCH_QUEUE_PERF_EN
    ,
    .perf_full_cyc   (perf_full_cyc),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  function automatic id_dispatch_t mk(input int k);
    id_dispatch_t d;
    d.pc     = 32'h1000 + k;
    d.instr  = 32'hA500_0000 ^ k;
    d.rd     = k[4:0];
    d.fu_sel = k[3:0];
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] v, input int a, input int b, input logic [1:0] pop);
    in_valid    = v;
    in_data[0]  = mk(a);
    in_data[1]  = mk(b);
    out_pop_cnt = pop;
    cyc();
    in_valid    = 2'b00;
    out_pop_cnt = 2'd0;
  endtask

  initial begin
    rst = 1'b1; exception_flush = 1'b0; branch_flush = 1'b0;
    in_valid = '0; in_data = '0; out_pop_cnt = '0;
    cyc(); cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $error("FAIL rst_in_ready"); end
    checks++; if (out_valid !== 2'b00) begin errors++; $error("FAIL rst_out_valid"); end
    checks++; if (out_data[0] !== zero_d) begin errors++; $error("FAIL rst_out_data0"); end
    rst = 1'b0;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL rel_in_ready"); end
    checks++; if (dut.count !== 4'd0) begin errors++; $error("FAIL rel_count"); end

    step(2'b11, 1, 2, 2'd0);
    step(2'b11, 3, 4, 2'd0);
    step(2'b01, 5, 0, 2'd0);
    checks++; if (dut.count !== 4'd5) begin errors++; $error("FAIL mid_count5"); end
    checks++; if (out_valid !== 2'b11) begin errors++; $error("FAIL mid_out_valid"); end
    checks++; if (out_data[0] !== mk(1)) begin errors++; $error("FAIL mid_out0"); end
    checks++; if (out_data[1] !== mk(2)) begin errors++; $error("FAIL mid_out1"); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $error("FAIL mid_rst_out_valid"); end
    checks++; if (in_ready !== 1'b0) begin errors++; $error("FAIL mid_rst_in_ready"); end
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL mid_rel_in_ready"); end
    checks++; if (dut.count !== 4'd0) begin errors++; $error("FAIL mid_rel_count"); end

    step(2'b11, 10, 11, 2'd0);
    step(2'b11, 12, 13, 2'd0);
    step(2'b11, 14, 15, 2'd0);
    checks++; if (dut.count !== 4'd6) begin errors++; $error("FAIL fill6_count"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL fill6_in_ready"); end
    step(2'b01, 16, 0, 2'd0);
    checks++; if (dut.count !== 4'd7) begin errors++; $error("FAIL fill7_count"); end
    checks++; if (in_ready !== 1'b0) begin errors++; $error("FAIL fill7_in_ready"); end
    step(2'b11, 17, 18, 2'd0);
    checks++; if (dut.count !== 4'd7) begin errors++; $error("FAIL full_ignore_count"); end
    checks++; if (out_data[0] !== mk(10)) begin errors++; $error("FAIL full_out0"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_data[0] !== mk(12)) begin errors++; $error("FAIL drain_out0_12"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_data[1] !== mk(15)) begin errors++; $error("FAIL drain_out1_15"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_valid !== 2'b01) begin errors++; $error("FAIL drain_valid_01"); end
    checks++; if (out_data[0] !== mk(16)) begin errors++; $error("FAIL drain_out0_16"); end
    checks++; if (out_data[1] !== zero_d) begin errors++; $error("FAIL drain_out1_zero"); end
    step(2'b00, 0, 0, 2'd1);
    checks++; if (out_valid !== 2'b00) begin errors++; $error("FAIL drain_empty"); end

    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    step(2'b11, 20, 21, 2'd0);
    step(2'b11, 22, 23, 2'd0);
    step(2'b11, 24, 25, 2'd0);
    step(2'b00, 0, 0, 2'd2);
    step(2'b00, 0, 0, 2'd2);
    step(2'b00, 0, 0, 2'd2);
    checks++; if (dut.head !== 3'd6) begin errors++; $error("FAIL wrap_head6"); end
    checks++; if (dut.tail !== 3'd6) begin errors++; $error("FAIL wrap_tail6"); end
    step(2'b11, 30, 31, 2'd0);
    checks++; if (out_data[0] !== mk(30)) begin errors++; $error("FAIL wrap_out0_A"); end
    checks++; if (out_data[1] !== mk(31)) begin errors++; $error("FAIL wrap_out1_B"); end
    step(2'b11, 32, 33, 2'd0);
    checks++; if (dut.count !== 4'd4) begin errors++; $error("FAIL wrap_count4"); end
    checks++; if (dut.u_ring.mem[6] !== mk(30)) begin errors++; $error("FAIL wrap_mem6"); end
    checks++; if (dut.u_ring.mem[7] !== mk(31)) begin errors++; $error("FAIL wrap_mem7"); end
    checks++; if (dut.u_ring.mem[0] !== mk(32)) begin errors++; $error("FAIL wrap_mem0"); end
    checks++; if (dut.u_ring.mem[1] !== mk(33)) begin errors++; $error("FAIL wrap_mem1"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_data[0] !== mk(32)) begin errors++; $error("FAIL wrap_out0_C"); end
    checks++; if (out_data[1] !== mk(33)) begin errors++; $error("FAIL wrap_out1_D"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_valid !== 2'b00) begin errors++; $error("FAIL wrap_empty"); end
    checks++; if (dut.head !== 3'd2) begin errors++; $error("FAIL wrap_head2"); end

    step(2'b11, 40, 41, 2'd0);
    step(2'b11, 42, 43, 2'd0);
    step(2'b11, 44, 45, 2'd0);
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL sim_pre_in_ready"); end
    step(2'b11, 46, 47, 2'd2);
    checks++; if (dut.count !== 4'd6) begin errors++; $error("FAIL sim_count6"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL sim_in_ready"); end
    checks++; if (out_data[0] !== mk(42)) begin errors++; $error("FAIL sim_out0_42"); end
    checks++; if (out_data[1] !== mk(43)) begin errors++; $error("FAIL sim_out1_43"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_data[0] !== mk(44)) begin errors++; $error("FAIL sim_out0_44"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (out_data[1] !== mk(47)) begin errors++; $error("FAIL sim_out1_47"); end
    step(2'b00, 0, 0, 2'd2);
    checks++; if (dut.count !== 4'd0) begin errors++; $error("FAIL sim_empty"); end

    step(2'b11, 50, 51, 2'd0);
    step(2'b11, 52, 53, 2'd0);
    checks++; if (dut.count !== 4'd4) begin errors++; $error("FAIL fl_count4"); end
    branch_flush = 1'b1;
    step(2'b11, 54, 55, 2'd1);
    branch_flush = 1'b0;
    checks++; if (dut.count !== 4'd0) begin errors++; $error("FAIL fl_count0"); end
    checks++; if (out_valid !== 2'b00) begin errors++; $error("FAIL fl_out_valid"); end
    checks++; if (out_data[0] !== zero_d) begin errors++; $error("FAIL fl_out0_zero"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $error("FAIL fl_in_ready"); end
    checks++; if (dut.tail !== 3'd0) begin errors++; $error("FAIL fl_tail0"); end
    step(2'b11, 60, 61, 2'd0);
    exception_flush = 1'b1; branch_flush = 1'b1;
    step(2'b00, 0, 0, 2'd0);
    exception_flush = 1'b0; branch_flush = 1'b0;
    checks++; if (dut.count !== 4'd0) begin errors++; $error("FAIL fl_both_count0"); end
    step(2'b11, 70, 71, 2'd0);
    checks++; if (out_data[0] !== mk(70)) begin errors++; $error("FAIL fl_post_out0"); end
    checks++; if (out_data[1] !== mk(71)) begin errors++; $error("FAIL fl_post_out1"); end
    step(2'b00, 0, 0, 2'd2);

`ifdef ID_DISPATCH_QUEUE_PERF_EN
    rst = 1'b1; cyc();
    checks++; if (perf_full_cyc !== 32'd0) begin errors++; $error("FAIL perf_rst_full"); end
    checks++; if (perf_flush_cnt !== 32'd0) begin errors++; $error("FAIL perf_rst_flush"); end
    rst = 1'b0; cyc();
    step(2'b11, 80, 81, 2'd0);
    step(2'b11, 82, 83, 2'd0);
    step(2'b11, 84, 85, 2'd0);
    step(2'b11, 86, 87, 2'd0);
    checks++; if (in_ready !== 1'b0) begin errors++; $error("FAIL perf_full_ready"); end
    checks++; if (perf_full_cyc !== 32'd0) begin errors++; $error("FAIL perf_full0"); end
    step(2'b00, 0, 0, 2'd0);
    step(2'b00, 0, 0, 2'd0);
    step(2'b00, 0, 0, 2'd2);
    checks++; if (perf_full_cyc !== 32'd3) begin errors++; $error("FAIL perf_full3"); end
    branch_flush = 1'b1;
    step(2'b00, 0, 0, 2'd0);
    branch_flush = 1'b0; exception_flush = 1'b1;
    step(2'b00, 0, 0, 2'd0);
    exception_flush = 1'b0;
    checks++; if (perf_flush_cnt !== 32'd2) begin errors++; $error("FAIL perf_flush2"); end
    checks++; if (perf_full_cyc !== 32'd3) begin errors++; $error("FAIL perf_full_hold3"); end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
